// File: rtl/avalon_sdram_responder.sv
// Avalon-MM pipelined responder backed by a 2^MEM_AW x 16 on-chip memory.
// Fixed read latency, bounded outstanding reads, optional periodic one-cycle stall.
module avalon_sdram_responder #(
    parameter int MEM_AW     = 10,
    parameter int READ_LAT   = 3,
    parameter int MAX_PEND   = 4,
    parameter int WAIT_EVERY = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [31:0] address,
    input  logic [1:0]  byteenable,
    input  logic [15:0] writedata,
    output logic        waitrequest,
    output logic [15:0] readdata,
    output logic        readdatavalid,
    output logic        err
);
    localparam int PW = $clog2(MAX_PEND + 1);
    localparam int CW = (WAIT_EVERY > 1) ? $clog2(WAIT_EVERY) : 1;

    logic [15:0]               r_mem [0:(1<<MEM_AW)-1];
    logic [READ_LAT-1:0]       r_vld;
    logic [READ_LAT-1:0][15:0] r_dat;
    logic [PW-1:0]             r_pend;
    logic [CW-1:0]             r_acc;
    logic                      r_stall;
    logic                      r_first;
    logic                      r_err;

    logic              w_rd, w_wr, w_both, w_oor, w_ret, w_full;
    logic [MEM_AW-1:0] w_idx;
    logic [15:0]       w_rdval;

    // A return in the current cycle frees a slot, so a full pipe still accepts.
    assign w_ret       = r_vld[READ_LAT-1];
    assign w_full      = (r_pend == PW'(MAX_PEND)) && !w_ret;
    assign waitrequest = r_first | r_stall | w_full;

    assign w_oor   = |address[31:MEM_AW];
    assign w_idx   = address[MEM_AW-1:0];
    assign w_rd    = chipselect & ~waitrequest & ~read_n &  write_n;
    assign w_wr    = chipselect & ~waitrequest &  read_n & ~write_n;
    assign w_both  = chipselect & ~waitrequest & ~read_n & ~write_n;
    assign w_rdval = w_oor ? 16'h0000 : r_mem[w_idx];

    assign readdatavalid = w_ret;
    assign readdata      = r_dat[READ_LAT-1];
    assign err           = r_err;

    // Memory is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (w_wr && !w_oor) begin
            if (byteenable[0]) r_mem[w_idx][7:0]  <= writedata[7:0];
            if (byteenable[1]) r_mem[w_idx][15:8] <= writedata[15:8];
        end
    end

    // Read pipe: the last stage doubles as the held readdata register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld <= '0;
            r_dat <= '0;
        end else begin
            r_vld[0] <= w_rd;
            if (w_rd) r_dat[0] <= w_rdval;
            for (int i = 1; i < READ_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) r_dat[i] <= r_dat[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend  <= '0;
            r_first <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_first <= 1'b0;
            if (w_rd && !w_ret)      r_pend <= r_pend + PW'(1);
            else if (!w_rd && w_ret) r_pend <= r_pend - PW'(1);
            if (w_both || ((w_rd || w_wr) && w_oor)) r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc   <= '0;
            r_stall <= 1'b0;
        end else if ((WAIT_EVERY > 0) && (w_rd || w_wr)) begin
            if (r_acc == CW'(WAIT_EVERY - 1)) begin
                r_acc   <= '0;
                r_stall <= 1'b1;
            end else begin
                r_acc   <= r_acc + CW'(1);
                r_stall <= 1'b0;
            end
        end else begin
            r_stall <= 1'b0;
        end
    end
endmodule
